tcb_lib_latency_adapter: RTL and testbench

- Sits between a TCB manager and a TCB subordinate that run with different fixed response delays.
- The subordinate returns read data DLY_SUB cycles after a transfer; the manager expects it DLY_MAN cycles after (DLY_MAN >= DLY_SUB).
- The request path passes straight through. The response path is re-timed by a valid-gated delay pipeline, with optional hold of the last response and an outstanding-transfer counter for the manager.

---
 rtl/tcb_lib_latency_adapter.sv | 172 +++++++++++++++++
 tb/tb_tcb_lib_latency_adapter.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/tcb_lib_latency_adapter.sv
// TCB latency adapter: passes requests straight through and re-times the
// subordinate response (delay DLY_SUB) to the manager's delay (DLY_MAN)
// with a valid-gated pipeline, an optional hold register and an
// outstanding-transfer counter.

// Bound checker: the outstanding count can never exceed the response delay.
module tcb_lib_latency_adapter_chk #(
   parameter int DLY_MAN = 2,
   parameter int CW      = 2
)(
   input  logic          clk,
   input  logic          rst,
   input  logic [CW-1:0] cnt
);

   cnt_bound_a: assert property (@(posedge clk) disable iff (rst) (int'(cnt) <= DLY_MAN));

endmodule

module tcb_lib_latency_adapter #(
   parameter int ADR     = 32,
   parameter int DAT     = 32,
   parameter int SIZ     = $clog2($clog2(DAT/8)+1),
   parameter int DLY_SUB = 1,
   parameter int DLY_MAN = 2,
   parameter int HLD     = 1
)(
   input  logic                         clk,
   input  logic                         rst,
   // manager side
   input  logic                         man_vld,
   output logic                         man_rdy,
   input  logic                         man_wen,
   input  logic [ADR-1:0]               man_adr,
   input  logic [SIZ-1:0]               man_siz,
   input  logic [DAT-1:0]               man_wdt,
   output logic [DAT-1:0]               man_rdt,
   output logic                         man_err,
   output logic                         man_rsp_vld,
   // subordinate side
   output logic                         sub_vld,
   input  logic                         sub_rdy,
   output logic                         sub_wen,
   output logic [ADR-1:0]               sub_adr,
   output logic [SIZ-1:0]               sub_siz,
   output logic [DAT-1:0]               sub_wdt,
   input  logic [DAT-1:0]               sub_rdt,
   input  logic                         sub_err,
   // outstanding transfers
   output logic [$clog2(DLY_MAN+2)-1:0] cnt
);

   localparam int CW = $clog2(DLY_MAN+2);
   localparam int RW = DAT + 1;   // {err, rdt}

   generate
      if (DLY_MAN < DLY_SUB) begin : g_bad_dly
         $error("tcb_lib_latency_adapter: DLY_MAN must be >= DLY_SUB");
      end
   endgenerate

   logic              trn_s;
   logic              rsp_vld_s;
   logic [DLY_MAN:0]  trk_s;
   logic [RW-1:0]     stg_s [DLY_SUB:DLY_MAN];
   logic [RW-1:0]     hld_r;
   logic [RW-1:0]     out_s;
   logic [CW-1:0]     cnt_r;

   // request path is a pure passthrough
   assign sub_vld = man_vld;
   assign man_rdy = sub_rdy;
   assign sub_wen = man_wen;
   assign sub_adr = man_adr;
   assign sub_siz = man_siz;
   assign sub_wdt = man_wdt;

   assign trn_s    = man_vld & sub_rdy;
   assign trk_s[0] = trn_s;

   generate
      if (DLY_MAN > 0) begin : g_trk
         logic [DLY_MAN:1] trk_r;

         // transfer-valid shift register: one bit per cycle of delay
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               trk_r <= '0;
            end else begin
               trk_r <= trk_s[DLY_MAN-1:0];
            end
         end

         assign trk_s[DLY_MAN:1] = trk_r;
      end
   endgenerate

   // the subordinate response enters the pipeline at stage DLY_SUB
   assign stg_s[DLY_SUB] = {sub_err, sub_rdt};

   generate
      for (genvar i = DLY_SUB + 1; i <= DLY_MAN; i++) begin : g_stg
         logic [RW-1:0] stg_r;

         // stage only loads when a response is actually moving through it
         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               stg_r <= '0;
            end else if (trk_s[i-1]) begin
               stg_r <= stg_s[i-1];
            end else begin
               stg_r <= stg_r;
            end
         end

         assign stg_s[i] = stg_r;
      end
   endgenerate

   assign rsp_vld_s = trk_s[DLY_MAN];

   // hold register remembers the last delivered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         hld_r <= '0;
      end else if (rsp_vld_s) begin
         hld_r <= stg_s[DLY_MAN];
      end else begin
         hld_r <= hld_r;
      end
   end

   // manager response: live data when due, otherwise held value or zero
   always_comb begin
      out_s = '0;
      if (rsp_vld_s) begin
         out_s = stg_s[DLY_MAN];
      end else if (HLD != 0) begin
         out_s = hld_r;
      end else begin
         out_s = '0;
      end
   end

   // outstanding counter: +1 per accepted transfer, -1 per delivered response
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_r <= '0;
      end else begin
         case ({trn_s, rsp_vld_s})
            2'b10:   cnt_r <= cnt_r + CW'(1'b1);
            2'b01:   cnt_r <= cnt_r - CW'(1'b1);
            default: cnt_r <= cnt_r;
         endcase
      end
   end

   assign man_rdt     = out_s[DAT-1:0];
   assign man_err     = out_s[DAT];
   assign man_rsp_vld = rsp_vld_s;
   assign cnt         = cnt_r;

   tcb_lib_latency_adapter_chk #(
      .DLY_MAN (DLY_MAN),
      .CW      (CW)
   ) u_chk (
      .clk (clk),
      .rst (rst),
      .cnt (cnt_r)
   );

endmodule

// File: tb/tb_tcb_lib_latency_adapter.sv
// Bench for tcb_lib_latency_adapter: three configurations share one stimulus
// stream; a cycle-history model predicts every output each cycle.
module tb_tcb_lib_latency_adapter;

   localparam int N     = 4096;
   localparam int LAST  = 2110;

   logic        clk = 1'b0;
   logic        rst;
   logic        man_vld, man_wen, sub_rdy, sub_err;
   logic [31:0] man_adr, man_wdt, sub_rdt;
   logic [1:0]  man_siz;

   logic        a_rdy, a_rsp, a_err, a_svld, a_swen;
   logic [31:0] a_rdt, a_sadr, a_swdt;
   logic [1:0]  a_ssiz;
   logic [2:0]  a_cnt;
   logic        b_rdy, b_rsp, b_err, b_svld, b_swen;
   logic [31:0] b_rdt, b_sadr, b_swdt;
   logic [1:0]  b_ssiz;
   logic [1:0]  b_cnt;
   logic        c_rdy, c_rsp, c_err, c_svld, c_swen;
   logic [31:0] c_rdt, c_sadr, c_swdt;
   logic [1:0]  c_ssiz;
   logic [1:0]  c_cnt;

   bit          trn_h [N];
   bit          rst_h [N];
   logic [32:0] dat_h [N];
   int          cyc;
   int          n_tests;
   int          n_fail;
   int          rst_left;
   int          a_pulses;
   logic [32:0] hold_a, hold_b, hold_c;

   always #5 clk = ~clk;

   tcb_lib_latency_adapter #(.DLY_SUB(1), .DLY_MAN(3), .HLD(1)) u_a (
      .clk(clk), .rst(rst),
      .man_vld(man_vld), .man_rdy(a_rdy), .man_wen(man_wen), .man_adr(man_adr),
      .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(a_rdt), .man_err(a_err),
      .man_rsp_vld(a_rsp),
      .sub_vld(a_svld), .sub_rdy(sub_rdy), .sub_wen(a_swen), .sub_adr(a_sadr),
      .sub_siz(a_ssiz), .sub_wdt(a_swdt), .sub_rdt(sub_rdt), .sub_err(sub_err),
      .cnt(a_cnt));

   tcb_lib_latency_adapter #(.DLY_SUB(0), .DLY_MAN(2), .HLD(0)) u_b (
      .clk(clk), .rst(rst),
      .man_vld(man_vld), .man_rdy(b_rdy), .man_wen(man_wen), .man_adr(man_adr),
      .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(b_rdt), .man_err(b_err),
      .man_rsp_vld(b_rsp),
      .sub_vld(b_svld), .sub_rdy(sub_rdy), .sub_wen(b_swen), .sub_adr(b_sadr),
      .sub_siz(b_ssiz), .sub_wdt(b_swdt), .sub_rdt(sub_rdt), .sub_err(sub_err),
      .cnt(b_cnt));

   tcb_lib_latency_adapter #(.DLY_SUB(1), .DLY_MAN(1), .HLD(1)) u_c (
      .clk(clk), .rst(rst),
      .man_vld(man_vld), .man_rdy(c_rdy), .man_wen(man_wen), .man_adr(man_adr),
      .man_siz(man_siz), .man_wdt(man_wdt), .man_rdt(c_rdt), .man_err(c_err),
      .man_rsp_vld(c_rsp),
      .sub_vld(c_svld), .sub_rdy(sub_rdy), .sub_wen(c_swen), .sub_adr(c_sadr),
      .sub_siz(c_ssiz), .sub_wdt(c_swdt), .sub_rdt(sub_rdt), .sub_err(sub_err),
      .cnt(c_cnt));

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s cycle=%0d actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // returns 1 when rst stayed low throughout cycles s..t (a transfer survives)
   function automatic bit clean(input int s, input int t);
      if (s < 0) return 1'b0;
      for (int k = s; k <= t; k++) begin
         if (rst_h[k]) return 1'b0;
      end
      return 1'b1;
   endfunction

   // what a (ds,dm) adapter must show in cycle t, from the cycle history
   function automatic void model(input int ds, input int dm, input int t,
                                 output bit vld, output logic [32:0] dat, output int cn);
      vld = 1'b0;
      dat = 33'd0;
      cn  = 0;
      if (t - dm >= 0) begin
         vld = trn_h[t-dm] && clean(t - dm, t);
         dat = dat_h[t-dm+ds];
      end
      for (int s = t - dm; s <= t - 1; s++) begin
         if (s >= 0 && trn_h[s] && clean(s, t)) cn++;
      end
   endfunction

   task automatic chk_inst(input string nm, input int ds, input int dm, input bit hp,
                           input bit av, input logic [31:0] ard, input bit aer, input int acn,
                           input logic [36:0] actl, input logic [31:0] awdt,
                           input logic [32:0] hin, output logic [32:0] hout);
      bit          ev;
      logic [32:0] ed, eo;
      int          ec;
      model(ds, dm, cyc, ev, ed, ec);
      if (rst_h[cyc]) begin
         eo = 33'd0; hout = 33'd0;
      end else if (ev) begin
         eo = ed; hout = ed;
      end else begin
         eo = hp ? hin : 33'd0; hout = hin;
      end
      check({nm, "_rsp_vld"}, 64'(av), 64'(ev));
      check({nm, "_rdt"}, 64'(ard), 64'(eo[31:0]));
      check({nm, "_err"}, 64'(aer), 64'(eo[32]));
      check({nm, "_cnt"}, 64'(acn), 64'(ec));
      check({nm, "_req_pass"}, 64'(actl), 64'({man_vld, sub_rdy, man_wen, man_siz, man_adr}));
      check({nm, "_wdt_pass"}, 64'(awdt), 64'(man_wdt));
   endtask

   task automatic drive(input int c);
      bit          r, v, rdy, er;
      logic [31:0] rd;
      if (c < 100) begin
         r   = (c < 2) || (c == 82);
         v   = (c == 10) || (c == 30) || (c >= 40 && c <= 49) ||
               (c >= 60 && c <= 63) || (c == 80) || (c == 81);
         rdy = !(c >= 60 && c <= 62);
         rd  = 32'h5500_0000 | 32'(c);
         er  = 1'b0;
         if (c == 11) rd = 32'hDEAD_BEEF;
         if (c == 30) begin
            rd = 32'hA5A5_A5A5; er = 1'b1;
         end
         if (c >= 41 && c <= 50) rd = 32'h0000_0100 + 32'(c - 41);
      end else begin
         if (rst_left > 0) begin
            r = 1'b1; rst_left--;
         end else if (c < LAST - 10 && $urandom_range(0, 199) == 0) begin
            r = 1'b1; rst_left = int'($urandom_range(0, 2));
         end else begin
            r = 1'b0;
         end
         v   = (c < LAST - 10) && ($urandom_range(0, 9) < 7);
         rdy = $urandom_range(0, 9) < 8;
         rd  = $urandom;
         er  = 1'($urandom_range(0, 1));
      end
      rst     = r;
      man_vld = v;
      sub_rdy = rdy;
      sub_rdt = rd;
      sub_err = er;
      man_wen = 1'($urandom_range(0, 1));
      man_adr = $urandom;
      man_wdt = $urandom;
      man_siz = 2'($urandom_range(0, 3));
      rst_h[c] = r;
      trn_h[c] = v & rdy;
      dat_h[c] = {er, rd};
   endtask

   // per-cycle comparison against the model plus hand-derived literal points
   always @(negedge clk) begin
      if (cyc >= 1) begin
         chk_inst("A", 1, 3, 1'b1, a_rsp, a_rdt, a_err, int'(a_cnt),
                  {a_svld, a_rdy, a_swen, a_ssiz, a_sadr}, a_swdt, hold_a, hold_a);
         chk_inst("B", 0, 2, 1'b0, b_rsp, b_rdt, b_err, int'(b_cnt),
                  {b_svld, b_rdy, b_swen, b_ssiz, b_sadr}, b_swdt, hold_b, hold_b);
         chk_inst("C", 1, 1, 1'b1, c_rsp, c_rdt, c_err, int'(c_cnt),
                  {c_svld, c_rdy, c_swen, c_ssiz, c_sadr}, c_swdt, hold_c, hold_c);

         if (cyc == 1) check("lit_reset_state", 64'({a_rsp, a_err, a_rdt, a_cnt}), 64'd0);
         if (cyc == 12) check("lit_a_12", 64'({a_rsp, a_cnt}), 64'({1'b0, 3'd1}));
         if (cyc == 13) check("lit_a_13", 64'({a_rsp, a_rdt, a_cnt}), 64'({1'b1, 32'hDEAD_BEEF, 3'd1}));
         if (cyc == 14 || cyc == 20)
            check("lit_a_hold", 64'({a_rsp, a_rdt, a_cnt}), 64'({1'b0, 32'hDEAD_BEEF, 3'd0}));
         if (cyc == 11) check("lit_c_11", 64'({c_rsp, c_rdt}), 64'({1'b1, 32'hDEAD_BEEF}));
         if (cyc == 12) check("lit_c_hold", 64'({c_rsp, c_rdt}), 64'({1'b0, 32'hDEAD_BEEF}));
         if (cyc == 31 || cyc == 33) check("lit_b_zero", 64'({b_rsp, b_err, b_rdt}), 64'd0);
         if (cyc == 32) check("lit_b_32", 64'({b_rsp, b_err, b_rdt}), 64'({1'b1, 1'b1, 32'hA5A5_A5A5}));
         if (cyc >= 43 && cyc <= 52)
            check("lit_a_burst", 64'({a_rsp, a_rdt}), 64'({1'b1, 32'h0000_0100 + 32'(cyc - 43)}));
         if (cyc == 45) check("lit_a_cnt_peak", 64'(a_cnt), 64'd3);
         if (cyc >= 60 && cyc <= 75 && a_rsp) a_pulses++;
         if (cyc == 66) check("lit_a_stall_rsp", 64'(a_rsp), 64'd1);
         if (cyc == 76) check("lit_a_one_pulse", 64'(a_pulses), 64'd1);
         if (cyc == 81) check("lit_a_cnt_pre_rst", 64'(a_cnt), 64'd1);
         if (cyc == 82) check("lit_a_rst_async", 64'({a_rsp, a_rdt, a_cnt}), 64'd0);
         if (cyc == 83 || cyc == 84) check("lit_a_no_rsp_after_rst", 64'(a_rsp), 64'd0);
      end
   end

   initial begin
      cyc      = 0;
      n_tests  = 0;
      n_fail   = 0;
      rst_left = 0;
      a_pulses = 0;
      hold_a   = 33'd0;
      hold_b   = 33'd0;
      hold_c   = 33'd0;
      drive(0);
      for (int c = 1; c < LAST; c++) begin
         @(posedge clk);
         #1;
         cyc = c;
         drive(c);
      end
      @(posedge clk);
      #1;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
